// File: rtl/gate_vector_sequencer.sv
// Exhaustive sweep controller for an N_IN-input combinational gate.
// After a start pulse it walks every input vector 0 .. 2^N_IN-1, holds each
// for SETTLE cycles, samples the gate output and checks it against a built-in
// reduction model selected by OP (0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, abort    begin a sweep (IDLE only) / cancel a running sweep
//   vec_out         vector applied to the gate inputs
//   gate_y          gate output under test
//   busy, done      sweep running / one-cycle completion pulse
//   pass            last completed sweep had no mismatches
//   err_count       saturating mismatch count of current/last sweep
//   fail_vec/_valid first mismatching vector and its capture flag
//   log_valid/_vec/_y  one-cycle record of each checked vector
module gate_vector_sequencer #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned OP     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid,
  output logic            log_valid,
  output logic [N_IN-1:0] log_vec,
  output logic            log_y
);

  localparam int unsigned CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int unsigned ERR_W = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              fvalid_q, fvalid_d;
  logic              lvalid_q, lvalid_d;
  logic [N_IN-1:0]   lvec_q, lvec_d;
  logic              ly_q, ly_d;

  logic              exp_c;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_inc_c;

  // Reference response of the gate for the vector currently applied.
  always_comb begin
    exp_c = 1'b0;
    case (OP)
      0:       exp_c = &vec_q;
      1:       exp_c = |vec_q;
      2:       exp_c = ^vec_q;
      3:       exp_c = ~&vec_q;
      4:       exp_c = ~|vec_q;
      5:       exp_c = ~^vec_q;
      default: exp_c = 1'b0;
    endcase
  end

  // Mismatch detection and saturating increment of the error count.
  always_comb begin
    mismatch_c = (gate_y != exp_c);
    err_inc_c  = err_q;
    if (mismatch_c && (err_q != ERR_MAX)) begin
      err_inc_c = err_q + ERR_W'(1);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
    lvalid_d = 1'b0;
    lvec_d   = lvec_q;
    ly_d     = ly_q;

    case (state_q)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          state_d  = S_WAIT;
          vec_d    = '0;
          cnt_d    = CNT_LOAD;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
          busy_d   = 1'b1;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        // an abort discards this cycle's check entirely
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          err_d    = err_inc_c;
          lvalid_d = 1'b1;
          lvec_d   = vec_q;
          ly_d     = gate_y;
          if (mismatch_c && !fvalid_q) begin
            fvec_d   = vec_q;
            fvalid_d = 1'b1;
          end
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc_c == '0);
          end else begin
            state_d = S_WAIT;
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
      lvalid_q <= 1'b0;
      lvec_q   <= '0;
      ly_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
      lvalid_q <= lvalid_d;
      lvec_q   <= lvec_d;
      ly_q     <= ly_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;
  assign log_valid  = lvalid_q;
  assign log_vec    = lvec_q;
  assign log_y      = ly_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench for gate_vector_sequencer. Two instances:
//   index 0: N_IN=2, SETTLE=1, OP=AND    index 1: N_IN=3, SETTLE=3, OP=XOR
// The gate under test is modelled here (correct, stuck-at-0, stuck-at-1 or
// correct with a random per-vector flip mask). Expected log records and done
// summaries are queued when a sweep is launched and checked by a monitor.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_s [2];
  logic abort_s [2];
  logic gate_y_s[2];

  logic [1:0] vec_a, fvec_a, lvec_a;
  logic [2:0] err_a;
  logic       busy_a, done_a, pass_a, fvalid_a, lval_a, ly_a;
  logic [2:0] vec_b, fvec_b, lvec_b;
  logic [3:0] err_b;
  logic       busy_b, done_b, pass_b, fvalid_b, lval_b, ly_b;

  gate_vector_sequencer #(.N_IN(2), .SETTLE(1), .OP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .vec_out(vec_a), .gate_y(gate_y_s[0]), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .fail_vec(fvec_a), .fail_valid(fvalid_a),
    .log_valid(lval_a), .log_vec(lvec_a), .log_y(ly_a)
  );

  gate_vector_sequencer #(.N_IN(3), .SETTLE(3), .OP(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .vec_out(vec_b), .gate_y(gate_y_s[1]), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .fail_vec(fvec_b), .fail_valid(fvalid_b),
    .log_valid(lval_b), .log_vec(lvec_b), .log_y(ly_b)
  );

  // Uniform integer views of both instances.
  int vec_v[2], err_v[2], fvec_v[2], lvec_v[2];
  bit busy_v[2], done_v[2], pass_v[2], fvalid_v[2], lval_v[2], ly_v[2];

  always_comb begin
    vec_v[0] = int'(vec_a);   vec_v[1] = int'(vec_b);
    err_v[0] = int'(err_a);   err_v[1] = int'(err_b);
    fvec_v[0] = int'(fvec_a); fvec_v[1] = int'(fvec_b);
    lvec_v[0] = int'(lvec_a); lvec_v[1] = int'(lvec_b);
    busy_v[0] = busy_a;       busy_v[1] = busy_b;
    done_v[0] = done_a;       done_v[1] = done_b;
    pass_v[0] = pass_a;       pass_v[1] = pass_b;
    fvalid_v[0] = fvalid_a;   fvalid_v[1] = fvalid_b;
    lval_v[0] = lval_a;       lval_v[1] = lval_b;
    ly_v[0] = ly_a;           ly_v[1] = ly_b;
  end

  function automatic int n_of(int w);  return (w == 0) ? 2 : 3; endfunction
  function automatic int s_of(int w);  return (w == 0) ? 1 : 3; endfunction
  function automatic int op_of(int w); return (w == 0) ? 0 : 2; endfunction

  // Boolean function of the vector read as an integer.
  function automatic bit ref_fn(int op, int n, int v);
    int all;
    bit par;
    all = (1 << n) - 1;
    par = (($countones(v) % 2) == 1);
    case (op)
      0: return v == all;
      1: return v != 0;
      2: return par;
      3: return v != all;
      4: return v == 0;
      default: return !par;
    endcase
  endfunction

  int          mode[2];
  logic [255:0] mask[2];

  function automatic bit gate_fn(int md, logic [255:0] mk, int v, int w);
    case (md)
      1: return 1'b0;
      2: return 1'b1;
      3: return ref_fn(op_of(w), n_of(w), v) ^ mk[v];
      default: return ref_fn(op_of(w), n_of(w), v);
    endcase
  endfunction

  always_comb begin
    for (int w = 0; w < 2; w++) gate_y_s[w] = gate_fn(mode[w], mask[w], vec_v[w], w);
  end

  typedef struct { int vec; bit y; int cyc; } log_t;
  typedef struct { int err; int fvec; bit fvalid; bit pass; int cyc; } done_t;

  log_t  log_q0[$], log_q1[$];
  done_t done_q0[$], done_q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit last_pass[2];
  int p_err[2], p_fvec[2];
  bit p_fvalid[2], p_pass[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event without expectation (cycle %0d)", nm, cyc);
  endtask

  // Reference model: expected results of a sweep started at t0 that is cut
  // short before vector av is checked (av >= 2^n means it completes).
  task automatic model(input int w, input int av, input int t0);
    int n, s, nv, errmax, err, fv, lim;
    bit fval, y;
    log_t  le;
    done_t de;
    n = n_of(w); s = s_of(w); nv = 1 << n;
    errmax = (1 << (n + 1)) - 1;
    err = 0; fv = 0; fval = 1'b0;
    lim = (av < nv) ? av : nv;
    for (int v = 0; v < lim; v++) begin
      y = gate_fn(mode[w], mask[w], v, w);
      le.vec = v; le.y = y; le.cyc = t0 + (v + 1) * (s + 1) + 1;
      if (w == 0) log_q0.push_back(le); else log_q1.push_back(le);
      if (y != ref_fn(op_of(w), n, v)) begin
        if (err < errmax) err++;
        if (!fval) begin fv = v; fval = 1'b1; end
      end
    end
    p_err[w] = err; p_fvec[w] = fv; p_fvalid[w] = fval; p_pass[w] = (err == 0);
    if (av >= nv) begin
      de.err = err; de.fvec = fv; de.fvalid = fval; de.pass = (err == 0);
      de.cyc = t0 + nv * (s + 1) + 1;
      if (w == 0) done_q0.push_back(de); else done_q1.push_back(de);
    end
  endtask

  // Monitor: compare every log record and done pulse with the queued model.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (lval_v[w]) begin
        log_t le;
        int sz;
        sz = (w == 0) ? log_q0.size() : log_q1.size();
        if (sz == 0) fail_now($sformatf("log_unexpected[%0d]", w));
        else begin
          le = (w == 0) ? log_q0.pop_front() : log_q1.pop_front();
          chk($sformatf("log_vec[%0d]", w), lvec_v[w], le.vec);
          chk($sformatf("log_y[%0d]", w), int'(ly_v[w]), int'(le.y));
          chk($sformatf("log_cycle[%0d]", w), cyc, le.cyc);
        end
      end
      if (done_v[w]) begin
        done_t de;
        int sz;
        sz = (w == 0) ? done_q0.size() : done_q1.size();
        if (sz == 0) fail_now($sformatf("done_unexpected[%0d]", w));
        else begin
          de = (w == 0) ? done_q0.pop_front() : done_q1.pop_front();
          chk($sformatf("done_err[%0d]", w), err_v[w], de.err);
          chk($sformatf("done_fvec[%0d]", w), fvec_v[w], de.fvec);
          chk($sformatf("done_fvalid[%0d]", w), int'(fvalid_v[w]), int'(de.fvalid));
          chk($sformatf("done_pass[%0d]", w), int'(pass_v[w]), int'(de.pass));
          chk($sformatf("done_busy[%0d]", w), int'(busy_v[w]), 0);
          chk($sformatf("done_cycle[%0d]", w), cyc, de.cyc);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk({tag, "_vec"}, vec_v[w], 0);
      chk({tag, "_busy"}, int'(busy_v[w]), 0);
      chk({tag, "_done"}, int'(done_v[w]), 0);
      chk({tag, "_pass"}, int'(pass_v[w]), 0);
      chk({tag, "_err"}, err_v[w], 0);
      chk({tag, "_fvec"}, fvec_v[w], 0);
      chk({tag, "_fvalid"}, int'(fvalid_v[w]), 0);
      chk({tag, "_lvalid"}, int'(lval_v[w]), 0);
      chk({tag, "_lvec"}, lvec_v[w], 0);
      chk({tag, "_ly"}, int'(ly_v[w]), 0);
    end
  endtask

  // One sweep on instance w with gate mode md. If av < 2^n the sweep is
  // aborted (or reset) ph cycles after vector av first appears.
  task automatic run(input int w, input int md, input int av, input int ph,
                     input bit noisy, input bit use_rst);
    int nv, t0, ph_left;
    bit hit;
    nv = 1 << n_of(w);
    @(negedge clk);
    mode[w] = md;
    mask[w] = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start_s[w] = 1'b1;
    t0 = cyc;
    model(w, av, t0);
    @(negedge clk);
    start_s[w] = 1'b0;
    hit = 1'b0;
    ph_left = ph;
    for (int k = 0; k < 400 && !hit; k++) begin
      if (av < nv) begin
        if (busy_v[w] && vec_v[w] == av) begin
          if (ph_left == 0) begin
            hit = 1'b1;
            start_s[w] = 1'b0;
            if (use_rst) rst_n = 1'b0; else abort_s[w] = 1'b1;
          end else ph_left--;
        end
      end else if (done_v[w]) begin
        hit = 1'b1;
        start_s[w] = 1'b0;
        abort_s[w] = 1'($urandom % 2);
      end
      if (!hit) begin
        start_s[w] = noisy ? ($urandom % 3 == 0) : 1'b0;
        @(negedge clk);
      end
    end
    if (!hit) fail_now($sformatf("sweep_timeout[%0d]", w));
    @(negedge clk);
    abort_s[w] = 1'b0;
    rst_n = 1'b1;
    chk($sformatf("post_busy[%0d]", w), int'(busy_v[w]), 0);
    chk($sformatf("post_done[%0d]", w), int'(done_v[w]), 0);
    if (av >= nv) begin
      chk($sformatf("post_vec_hold[%0d]", w), vec_v[w], nv - 1);
      chk($sformatf("post_pass[%0d]", w), int'(pass_v[w]), int'(p_pass[w]));
      chk($sformatf("post_err[%0d]", w), err_v[w], p_err[w]);
      last_pass[w] = p_pass[w];
    end else if (use_rst) begin
      check_zero("mid_reset");
      last_pass[0] = 1'b0;
      last_pass[1] = 1'b0;
    end else begin
      chk($sformatf("abort_vec[%0d]", w), vec_v[w], av);
      chk($sformatf("abort_err[%0d]", w), err_v[w], p_err[w]);
      chk($sformatf("abort_fvec[%0d]", w), fvec_v[w], p_fvec[w]);
      chk($sformatf("abort_fvalid[%0d]", w), int'(fvalid_v[w]), int'(p_fvalid[w]));
      chk($sformatf("abort_pass[%0d]", w), int'(pass_v[w]), int'(last_pass[w]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, md, nv, av, ph;
    bit noisy, rs;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; mode[i] = 0; mask[i] = '0;
      last_pass[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // AND gate, N_IN=2: correct, stuck-at-0, stuck-at-1, correct again
    run(0, 0, 4, 0, 1'b0, 1'b0);
    chk("and_ok_err", err_v[0], 0);
    chk("and_ok_pass", int'(pass_v[0]), 1);
    chk("and_ok_fvalid", int'(fvalid_v[0]), 0);
    run(0, 1, 4, 0, 1'b0, 1'b0);
    chk("sa0_err", err_v[0], 1);
    chk("sa0_fvec", fvec_v[0], 3);
    chk("sa0_fvalid", int'(fvalid_v[0]), 1);
    chk("sa0_pass", int'(pass_v[0]), 0);
    run(0, 2, 4, 0, 1'b0, 1'b0);
    chk("sa1_err", err_v[0], 3);
    chk("sa1_fvec", fvec_v[0], 0);
    chk("sa1_pass", int'(pass_v[0]), 0);
    run(0, 0, 4, 0, 1'b0, 1'b0);
    chk("rerun_err", err_v[0], 0);
    chk("rerun_fvalid", int'(fvalid_v[0]), 0);
    chk("rerun_pass", int'(pass_v[0]), 1);

    // abort during vector 2's WAIT with a stuck-at-1 gate, then restart
    run(0, 2, 2, 0, 1'b0, 1'b0);
    chk("abort_plan_err", err_v[0], 2);
    chk("abort_plan_vec", vec_v[0], 2);
    run(0, 0, 4, 0, 1'b0, 1'b0);

    // start pulses while busy are ignored
    run(0, 1, 4, 0, 1'b1, 1'b0);

    // reset while vector 1 is waiting
    run(0, 2, 1, 0, 1'b0, 1'b1);

    // start together with abort in IDLE: stays idle
    @(negedge clk);
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("start_abort_busy", int'(busy_v[0]), 0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle", int'(busy_v[0]), 0);

    // XOR gate, N_IN=3, SETTLE=3
    run(1, 0, 8, 0, 1'b0, 1'b0);
    chk("xor_ok_pass", int'(pass_v[1]), 1);
    chk("xor_ok_err", err_v[1], 0);
    run(1, 3, 8, 0, 1'b1, 1'b0);

    // randomized sweeps
    for (int it = 0; it < 30; it++) begin
      w = int'($urandom % 2);
      md = int'($urandom % 4);
      nv = 1 << n_of(w);
      av = ($urandom % 4 == 0) ? int'($urandom % nv) : nv;
      ph = int'($urandom_range(0, s_of(w)));
      noisy = 1'($urandom % 2);
      rs = (av < nv) && ($urandom % 3 == 0);
      run(w, md, av, ph, noisy, rs);
    end

    repeat (5) @(negedge clk);
    chk("logq0_left", log_q0.size(), 0);
    chk("logq1_left", log_q1.size(), 0);
    chk("doneq0_left", done_q0.size(), 0);
    chk("doneq1_left", done_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
